// File: rtl/d_ledbar_seq_pkg.sv
// Shared FSM/mode types, CTRL field positions and register addresses for the
// LED-bar sequencer.
package d_ledbar_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_ROL    = 2'b00,
    MODE_ROR    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_MODE_LSB   = 1;
  localparam int CTRL_MODE_MSB   = 2;
  localparam int CTRL_RELOAD_LSB = 8;
  localparam int CTRL_RELOAD_MSB = 31;

  // Reserved CTRL bits [7:3] are never stored, so they always read back as 0.
  localparam logic [31:0] CTRL_WR_MASK = 32'hFFFF_FF07;

  localparam logic ADDR_CTRL    = 1'b0;
  localparam logic ADDR_PATTERN = 1'b1;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/d_ledbar_seq_step.sv
// One sequencer step: next pattern, bounce direction and blink phase for the
// current MODE. Blink phase ports exist only when LEDSEQ_BLINK_EN is defined.
module d_ledbar_seq_step
  import d_ledbar_seq_pkg::*;
(
`ifdef LEDSEQ_BLINK_EN
  input  logic        phase_i,
  output logic        phase_o,
`endif
  input  logic [31:0] pat_i,
  input  logic        dir_i,
  input  mode_e       mode_i,
  output logic [31:0] pat_o,
  output logic        dir_o,
  output logic [31:0] led_o,
  output logic        pulse_en_o
);

  always_comb begin
    pat_o      = pat_i;
    dir_o      = dir_i;
    led_o      = pat_i;
    pulse_en_o = 1'b1;
`ifdef LEDSEQ_BLINK_EN
    phase_o    = phase_i;
`endif
    case (mode_i)
      MODE_ROL: pat_o = {pat_i[30:0], pat_i[31]};
      MODE_ROR: pat_o = {pat_i[0], pat_i[31:1]};
      MODE_BOUNCE: begin
        // Reversal happens in the same step that hits the edge bit.
        if (pat_i != 32'd0) begin
          if (dir_i == DIR_LEFT) begin
            if (pat_i[31]) begin
              dir_o = DIR_RIGHT;
              pat_o = {1'b0, pat_i[31:1]};
            end else begin
              pat_o = {pat_i[30:0], 1'b0};
            end
          end else begin
            if (pat_i[0]) begin
              dir_o = DIR_LEFT;
              pat_o = {pat_i[30:0], 1'b0};
            end else begin
              pat_o = {1'b0, pat_i[31:1]};
            end
          end
        end
      end
      default: begin
`ifdef LEDSEQ_BLINK_EN
        phase_o = ~phase_i;
`else
        pulse_en_o = 1'b0;
`endif
      end
    endcase

    if (mode_i == MODE_BLINK) begin
`ifdef LEDSEQ_BLINK_EN
      led_o = phase_i ? pat_i : 32'd0;
`endif
    end else begin
      led_o = pat_o;
    end
  end

endmodule

// File: rtl/d_ledbar_seq.sv
// CPU-programmable pattern sequencer that periodically writes a d_ledbar.
// Optional blink mode is compiled in with LEDSEQ_BLINK_EN (otherwise MODE 11 holds).
module d_ledbar_seq
  import d_ledbar_seq_pkg::*;
#(
  parameter logic [31:0] SEED_RST = 32'h0000_0001
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        we_i,
  input  logic        addr_i,
  input  logic        be0_i,
  input  logic        be1_i,
  input  logic        be2_i,
  input  logic        be3_i,
  input  logic [31:0] din_i,
  output logic [31:0] drd_o,
  output logic        led_we_o,
  output logic [3:0]  led_be_o,
  output logic [31:0] led_din_o,
  output logic        busy_o
);

  state_e      state_q, state_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] pattern_q, pattern_d;
  logic [31:0] pat_q, pat_d;
  logic [23:0] cnt_q, cnt_d;
  logic        dir_q, dir_d;
  logic        led_we_q, led_we_d;
  logic [31:0] led_din_q, led_din_d;
`ifdef LEDSEQ_BLINK_EN
  logic        phase_q, phase_d;
  logic        step_phase;
`endif

  logic [3:0]  be;
  logic        wr_ctrl, wr_pat, running, expire, load_req, stop_req;
  logic [23:0] reload, reload_last;
  mode_e       mode;
  logic [31:0] step_pat, step_led;
  logic        step_dir, step_pulse_en;

  assign be        = {be3_i, be2_i, be1_i, be0_i};
  assign wr_ctrl   = we_i && (addr_i == ADDR_CTRL);
  assign wr_pat    = we_i && (addr_i == ADDR_PATTERN);
  assign ctrl_d    = wr_ctrl ? (be_merge(ctrl_q, din_i, be) & CTRL_WR_MASK) : ctrl_q;
  assign pattern_d = wr_pat ? be_merge(pattern_q, din_i, be) : pattern_q;

  assign running     = (state_q != ST_IDLE);
  assign mode        = mode_e'(ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB]);
  assign reload      = ctrl_q[CTRL_RELOAD_MSB:CTRL_RELOAD_LSB];
  assign reload_last = (reload == 24'd0) ? 24'd0 : reload - 24'd1;
  assign expire      = (cnt_q >= reload_last);
  assign stop_req    = wr_ctrl && !ctrl_d[CTRL_EN_BIT];
  assign load_req    = (wr_pat && running) || (wr_ctrl && ctrl_d[CTRL_EN_BIT] && !running);

  d_ledbar_seq_step u_step (
`ifdef LEDSEQ_BLINK_EN
    .phase_i    (phase_q),
    .phase_o    (step_phase),
`endif
    .pat_i      (pat_q),
    .dir_i      (dir_q),
    .mode_i     (mode),
    .pat_o      (step_pat),
    .dir_o      (step_dir),
    .led_o      (step_led),
    .pulse_en_o (step_pulse_en)
  );

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    led_we_d  = 1'b0;
    led_din_d = led_din_q;
`ifdef LEDSEQ_BLINK_EN
    phase_d   = phase_q;
`endif
    if (stop_req) begin
      state_d = ST_IDLE;
    end else if (load_req) begin
      state_d   = ST_LOAD;
      pat_d     = pattern_d;
      cnt_d     = 24'd0;
      dir_d     = DIR_LEFT;
      led_we_d  = 1'b1;
      led_din_d = pattern_d;
`ifdef LEDSEQ_BLINK_EN
      phase_d   = 1'b0;
`endif
    end else if (running) begin
      state_d = ST_RUN;
      if (expire) begin
        cnt_d = 24'd0;
        // A CPU write on the expiry edge drops this step; the interval restarts.
        if (!we_i && step_pulse_en) begin
          pat_d     = step_pat;
          dir_d     = step_dir;
          led_we_d  = 1'b1;
          led_din_d = step_led;
`ifdef LEDSEQ_BLINK_EN
          phase_d   = step_phase;
`endif
        end
      end else begin
        cnt_d = cnt_q + 24'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= 32'd0;
      pattern_q <= SEED_RST;
      pat_q     <= 32'd0;
      cnt_q     <= 24'd0;
      dir_q     <= DIR_LEFT;
      led_we_q  <= 1'b0;
      led_din_q <= 32'd0;
`ifdef LEDSEQ_BLINK_EN
      phase_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      pattern_q <= pattern_d;
      pat_q     <= pat_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      led_we_q  <= led_we_d;
      led_din_q <= led_din_d;
`ifdef LEDSEQ_BLINK_EN
      phase_q   <= phase_d;
`endif
    end
  end

  assign drd_o     = (addr_i == ADDR_CTRL) ? ctrl_q : (running ? pat_q : pattern_q);
  assign led_we_o  = led_we_q;
  assign led_be_o  = 4'hF;
  assign led_din_o = led_din_q;
  assign busy_o    = running;

endmodule

// File: tb/tb_d_ledbar_seq.sv
// Self-checking bench for d_ledbar_seq: directed spec scenarios plus randomized
// programming, compared every cycle against a behavioural register/LED model.
module tb_d_ledbar_seq;

  logic        clk_i, rst_in, we_i, addr_i;
  logic        be0_i, be1_i, be2_i, be3_i;
  logic [31:0] din_i, drd_o, led_din_o;
  logic        led_we_o, busy_o;
  logic [3:0]  led_be_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] pulses[$];

  // Behavioural model state
  logic [31:0] m_ctrl, m_pattern, m_pat, m_led;
  logic        m_run, m_we, m_dir_right, m_phase;
  int unsigned m_since;

  d_ledbar_seq #(.SEED_RST(32'h0000_0001)) dut (
    .clk_i     (clk_i),
    .rst_in    (rst_in),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .be0_i     (be0_i),
    .be1_i     (be1_i),
    .be2_i     (be2_i),
    .be3_i     (be3_i),
    .din_i     (din_i),
    .drd_o     (drd_o),
    .led_we_o  (led_we_o),
    .led_be_o  (led_be_o),
    .led_din_o (led_din_o),
    .busy_o    (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pulse_at(input int i);
    if (i < pulses.size()) return pulses[i];
    return 32'bx;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_ctrl = 32'd0; m_pattern = 32'h1; m_pat = 32'd0; m_led = 32'd0;
    m_run = 1'b0; m_we = 1'b0; m_dir_right = 1'b0; m_phase = 1'b0; m_since = 0;
  endtask

  task automatic model_advance(input logic [1:0] mode);
    case (mode)
      2'd0: begin m_pat = (m_pat << 1) | (m_pat >> 31); m_led = m_pat; m_we = 1'b1; end
      2'd1: begin m_pat = (m_pat >> 1) | (m_pat << 31); m_led = m_pat; m_we = 1'b1; end
      2'd2: begin
        if (m_pat != 0) begin
          if (!m_dir_right) begin
            if (m_pat >= 32'h8000_0000) begin m_dir_right = 1'b1; m_pat = m_pat >> 1; end
            else m_pat = m_pat << 1;
          end else begin
            if (m_pat % 2 == 1) begin m_dir_right = 1'b0; m_pat = m_pat << 1; end
            else m_pat = m_pat >> 1;
          end
        end
        m_led = m_pat; m_we = 1'b1;
      end
      default: begin
`ifdef LEDSEQ_BLINK_EN
        m_led = m_phase ? m_pat : 32'd0;
        m_phase = !m_phase;
        m_we = 1'b1;
`endif
      end
    endcase
  endtask

  task automatic model_edge();
    logic [3:0]  be;
    logic [31:0] c_new, p_new;
    int unsigned period;
    be = {be3_i, be2_i, be1_i, be0_i};
    c_new = m_ctrl;
    p_new = m_pattern;
    if (we_i && !addr_i) c_new = merge(m_ctrl, din_i, be) & 32'hFFFF_FF07;
    if (we_i && addr_i)  p_new = merge(m_pattern, din_i, be);
    period = (m_ctrl[31:8] == 24'd0) ? 1 : int'(m_ctrl[31:8]);
    m_we = 1'b0;
    if (we_i && !addr_i && !c_new[0]) begin
      m_run = 1'b0;
    end else if ((we_i && addr_i && m_run) || (we_i && !addr_i && !m_run)) begin
      m_run = 1'b1; m_pat = p_new; m_led = p_new; m_we = 1'b1;
      m_since = 0; m_dir_right = 1'b0; m_phase = 1'b0;
    end else if (m_run) begin
      m_since++;
      if (m_since >= period) begin
        m_since = 0;
        if (!we_i) model_advance(m_ctrl[2:1]);
      end
    end
    m_ctrl = c_new;
    m_pattern = p_new;
  endtask

  task automatic check_all();
    chk("led_we", 32'(led_we_o), 32'(m_we));
    chk("led_din", led_din_o, m_led);
    chk("busy", 32'(busy_o), 32'(m_run));
    chk("led_be", 32'(led_be_o), 32'hF);
    chk("drd", drd_o, addr_i ? (m_run ? m_pat : m_pattern) : m_ctrl);
    if (led_we_o) pulses.push_back(led_din_o);
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    #1;
    check_all();
    we_i = 1'b0;
    addr_i = 1'($urandom_range(0, 1));
  endtask

  task automatic wr(input logic a, input logic [3:0] be, input logic [31:0] d);
    we_i = 1'b1; addr_i = a; din_i = d;
    {be3_i, be2_i, be1_i, be0_i} = be;
    tick();
  endtask

  initial begin
    logic [31:0] held;
    int          npulse;
    logic [23:0] rl;
    logic [1:0]  md;

    rst_in = 1'b0; we_i = 1'b0; addr_i = 1'b0; din_i = 32'd0;
    {be3_i, be2_i, be1_i, be0_i} = 4'hF;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_led_we", 32'(led_we_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_led_be", 32'(led_be_o), 32'hF);
    chk("rst_led_din", led_din_o, 32'd0);
    chk("rst_drd_ctrl", drd_o, 32'd0);
    addr_i = 1'b1; #1;
    chk("rst_drd_pattern", drd_o, 32'h1);
    rst_in = 1'b1;

    // Byte enables and reserved CTRL bits
    wr(1'b1, 4'hF, 32'h1122_3344);
    wr(1'b1, 4'b1010, 32'hAABB_CCDD);
    addr_i = 1'b1; #1;
    chk("be_pattern", drd_o, 32'hAA22_CC44);
    wr(1'b0, 4'hF, 32'hFFFF_FFFE);
    addr_i = 1'b0; #1;
    chk("ctrl_reserved", drd_o, 32'hFFFF_FF06);
    chk("ctrl_en0_idle", 32'(busy_o), 32'd0);

    // Rotate-left, RELOAD=3
    wr(1'b0, 4'hF, 32'd0);
    wr(1'b1, 4'hF, 32'h1);
    pulses.delete();
    wr(1'b0, 4'hF, 32'h0000_0301);
    repeat (9) tick();
    chk("rol_p0", pulse_at(0), 32'h1);
    chk("rol_p1", pulse_at(1), 32'h2);
    chk("rol_p2", pulse_at(2), 32'h4);
    chk("rol_p3", pulse_at(3), 32'h8);
    chk("rol_count", pulses.size(), 4);

    // Bounce, RELOAD=1
    wr(1'b0, 4'hF, 32'd0);
    wr(1'b1, 4'hF, 32'h4000_0000);
    pulses.delete();
    wr(1'b0, 4'hF, 32'h0000_0105);
    repeat (3) tick();
    chk("bnc_p0", pulse_at(0), 32'h4000_0000);
    chk("bnc_p1", pulse_at(1), 32'h8000_0000);
    chk("bnc_p2", pulse_at(2), 32'h4000_0000);
    chk("bnc_p3", pulse_at(3), 32'h2000_0000);

    // RELOAD=0 rotate-right: strobe every cycle
    wr(1'b0, 4'hF, 32'd0);
    wr(1'b1, 4'hF, 32'h1);
    pulses.delete();
    wr(1'b0, 4'hF, 32'h0000_0003);
    repeat (2) tick();
    chk("ror0_count", pulses.size(), 3);
    chk("ror0_p1", pulse_at(1), 32'h8000_0000);
    chk("ror0_p2", pulse_at(2), 32'h4000_0000);

    // EN=0 mid-interval: idle next cycle, bar holds
    wr(1'b0, 4'hF, 32'd0);
    wr(1'b1, 4'hF, 32'h1);
    wr(1'b0, 4'hF, 32'h0000_0501);
    repeat (7) tick();
    wr(1'b0, 4'hF, 32'h0000_0500);
    chk("stop_busy", 32'(busy_o), 32'd0);
    held = led_din_o;
    npulse = pulses.size();
    repeat (10) tick();
    chk("stop_hold", led_din_o, held);
    chk("stop_no_pulse", pulses.size(), npulse);

    // PATTERN write on the expiry edge replaces the step with a LOAD
    wr(1'b1, 4'hF, 32'h1);
    pulses.delete();
    wr(1'b0, 4'hF, 32'h0000_0401);
    repeat (3) tick();
    wr(1'b1, 4'hF, 32'h0000_00F0);
    chk("coll_we", 32'(led_we_o), 32'd1);
    chk("coll_din", led_din_o, 32'h0000_00F0);
    repeat (4) tick();
    chk("coll_p1", pulse_at(1), 32'h0000_00F0);
    chk("coll_p2", pulse_at(2), 32'h0000_01E0);
    chk("coll_count", pulses.size(), 3);

    // MODE change mid-interval keeps the interval running
    wr(1'b0, 4'hF, 32'd0);
    wr(1'b1, 4'hF, 32'h10);
    pulses.delete();
    wr(1'b0, 4'hF, 32'h0000_0401);
    repeat (6) tick();
    wr(1'b0, 4'hF, 32'h0000_0403);
    tick();
    chk("mode_p1", pulse_at(1), 32'h20);
    chk("mode_p2", pulse_at(2), 32'h10);

    // Blink (or hold when blink is compiled out)
    wr(1'b0, 4'hF, 32'd0);
    wr(1'b1, 4'hF, 32'hA5);
    pulses.delete();
    wr(1'b0, 4'hF, 32'h0000_0107);
    repeat (5) tick();
    chk("blink_p0", pulse_at(0), 32'hA5);
`ifdef LEDSEQ_BLINK_EN
    chk("blink_p1", pulse_at(1), 32'h0);
    chk("blink_p2", pulse_at(2), 32'hA5);
    chk("blink_p3", pulse_at(3), 32'h0);
`else
    chk("hold_count", pulses.size(), 1);
`endif

    // Randomized programming with occasional mid-run writes
    for (int it = 0; it < 24; it++) begin
      rl = 24'($urandom_range(0, 4));
      md = 2'($urandom_range(0, 3));
      wr(1'b0, 4'hF, 32'd0);
      wr(1'b1, 4'($urandom_range(1, 15)), $urandom);
      wr(1'b0, 4'hF, {rl, 5'd0, md, 1'b1});
      repeat ($urandom_range(3, 14)) begin
        if ($urandom_range(0, 7) == 0)
          wr(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom | 32'h1);
        else
          tick();
      end
    end

    // Asynchronous reset mid-RUN
    wr(1'b0, 4'hF, 32'd0);
    wr(1'b1, 4'hF, 32'h3);
    wr(1'b0, 4'hF, 32'h0000_0101);
    repeat (2) tick();
    chk("pre_rst_we", 32'(led_we_o), 32'd1);
    #2 rst_in = 1'b0;
    #1;
    model_reset();
    chk("arst_we", 32'(led_we_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_din", led_din_o, 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    chk("arst_hold_we", 32'(led_we_o), 32'd0);
    rst_in = 1'b1;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
